// File: rtl/winker_led_driver.sv
// winker_led_driver: turns the mode FSM's request levels into registered,
// blinking lamp drives. Blink phase comes from a prescaler, and completed
// blinks are counted.
// Optional lane-change auto-off: define WINKER_LANE_CHANGE_EN.
// HALF_PERIOD sets the number of cycles in each ON phase and each OFF phase.
// It must be at least 2.
module winker_led_driver #(
    parameter int HALF_PERIOD = 4,
    parameter int CNT_W       = 8,
    parameter int LANE_BLINKS = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_left_on,
    input  logic             i_right_on,
    input  logic             i_hazard,
    input  logic             i_finish,
    output logic             o_left_led,
    output logic             o_right_led,
    output logic             o_active,
    output logic [CNT_W-1:0] o_blink_cnt,
    output logic             o_auto_off
);

    localparam int PW = $clog2(HALF_PERIOD);
    localparam logic [PW-1:0]    PRESC_TERM = PW'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LEFT   = 2'd1,
        ST_RIGHT  = 2'd2,
        ST_HAZARD = 2'd3
    } state_t;

    state_t           state_q, state_d, req_state;
    logic [PW-1:0]    presc_q, presc_d;
    logic             phase_q, phase_d;       // 1 = ON phase
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             left_led_q, left_led_d;
    logic             right_led_q, right_led_d;
    logic             active_q, active_d;
    logic             auto_off_q, auto_off_d;
    logic             eff_left, eff_right;

`ifdef WINKER_LANE_CHANGE_EN
    // Per-direction lockout after an auto-off. It clears once the request level drops.
    logic blk_left_q, blk_left_d;
    logic blk_right_q, blk_right_d;
    assign eff_left  = i_left_on  & ~blk_left_q;
    assign eff_right = i_right_on & ~blk_right_q;
`else
    assign eff_left  = i_left_on;
    assign eff_right = i_right_on;
`endif

    // Request decode, blink sequencing and next values of the registered outputs.
    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        phase_d    = phase_q;
        cnt_d      = cnt_q;
        auto_off_d = 1'b0;
`ifdef WINKER_LANE_CHANGE_EN
        blk_left_d  = blk_left_q & i_left_on;
        blk_right_d = blk_right_q & i_right_on;
`endif
        // Decode in priority order. Left and right together keep the current state.
        if (i_finish)                   req_state = ST_IDLE;
        else if (i_hazard)              req_state = ST_HAZARD;
        else if (eff_left && !eff_right) req_state = ST_LEFT;
        else if (eff_right && !eff_left) req_state = ST_RIGHT;
        else if (eff_left && eff_right)  req_state = state_q;
        else                             req_state = ST_IDLE;

        if (req_state == ST_IDLE) begin
            // Stop right away. The count stays readable until the next start.
            state_d = ST_IDLE;
            presc_d = '0;
            phase_d = 1'b1;
        end else if (req_state != state_q) begin
            // New blinking state: restart in the ON phase with the count cleared.
            state_d = req_state;
            presc_d = '0;
            phase_d = 1'b1;
            cnt_d   = '0;
        end else if (presc_q == PRESC_TERM) begin
            presc_d = '0;
            phase_d = ~phase_q;
            if (phase_q && (cnt_q != CNT_MAX)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
`ifdef WINKER_LANE_CHANGE_EN
            if (phase_q && (state_q != ST_HAZARD) &&
                (cnt_d == CNT_W'(LANE_BLINKS))) begin
                state_d    = ST_IDLE;
                phase_d    = 1'b1;
                auto_off_d = 1'b1;
                if (state_q == ST_LEFT) blk_left_d  = 1'b1;
                else                    blk_right_d = 1'b1;
            end
`endif
        end else begin
            presc_d = presc_q + PW'(1);
        end

        left_led_d  = phase_d && ((state_d == ST_LEFT)  || (state_d == ST_HAZARD));
        right_led_d = phase_d && ((state_d == ST_RIGHT) || (state_d == ST_HAZARD));
        active_d    = (state_d != ST_IDLE);
    end

    // State and output registers. Reset is asynchronous, so the lamps drop without a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            presc_q     <= '0;
            phase_q     <= 1'b1;
            cnt_q       <= '0;
            left_led_q  <= 1'b0;
            right_led_q <= 1'b0;
            active_q    <= 1'b0;
            auto_off_q  <= 1'b0;
`ifdef WINKER_LANE_CHANGE_EN
            blk_left_q  <= 1'b0;
            blk_right_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            phase_q     <= phase_d;
            cnt_q       <= cnt_d;
            left_led_q  <= left_led_d;
            right_led_q <= right_led_d;
            active_q    <= active_d;
            auto_off_q  <= auto_off_d;
`ifdef WINKER_LANE_CHANGE_EN
            blk_left_q  <= blk_left_d;
            blk_right_q <= blk_right_d;
`endif
        end
    end

    assign o_left_led  = left_led_q;
    assign o_right_led = right_led_q;
    assign o_active    = active_q;
    assign o_blink_cnt = cnt_q;
    assign o_auto_off  = auto_off_q;

endmodule

// File: tb/tb_winker_led_driver.sv
// Directed bench for winker_led_driver (HALF_PERIOD=4, CNT_W=8, LANE_BLINKS=3).
// Inputs change 1 ns after a rising edge. Outputs are checked at that same point.
module tb_winker_led_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_left_on, i_right_on, i_hazard, i_finish;
    logic       o_left_led, o_right_led, o_active, o_auto_off;
    logic [7:0] o_blink_cnt;

    int n_cmp = 0;
    int n_mis = 0;

    winker_led_driver #(.HALF_PERIOD(4), .CNT_W(8), .LANE_BLINKS(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .i_left_on   (i_left_on),
        .i_right_on  (i_right_on),
        .i_hazard    (i_hazard),
        .i_finish    (i_finish),
        .o_left_led  (o_left_led),
        .o_right_led (o_right_led),
        .o_active    (o_active),
        .o_blink_cnt (o_blink_cnt),
        .o_auto_off  (o_auto_off)
    );

    // Clock, 10 ns period.
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // LED level expected k cycles after a (re)start with HALF_PERIOD=4.
    function automatic logic on_at(input int k);
        return (((k - 1) / 4) % 2) == 0;
    endfunction

    initial begin
        reset = 1'b1; i_left_on = 0; i_right_on = 0; i_hazard = 0; i_finish = 0;
        step(); step();
        check_eq("rst_left",   o_left_led, 0);
        check_eq("rst_right",  o_right_led, 0);
        check_eq("rst_active", o_active, 0);
        check_eq("rst_cnt",    o_blink_cnt, 0);
        check_eq("rst_auto",   o_auto_off, 0);
        reset = 1'b0;
        step();
        check_eq("idle_active", o_active, 0);

        // Blink left for 20 cycles. Lane auto-off would only fire at cycle 21.
        i_left_on = 1;
        for (int k = 1; k <= 20; k++) begin
            step();
            check_eq($sformatf("left_led_c%0d", k), o_left_led, on_at(k));
            check_eq($sformatf("left_rled_c%0d", k), o_right_led, 0);
            check_eq($sformatf("left_cnt_c%0d", k), o_blink_cnt, (k + 3) / 8);
            check_eq($sformatf("left_auto_c%0d", k), o_auto_off, 0);
        end
        check_eq("left_active", o_active, 1);

        // Switch to right while left is at cnt=2: immediate restart with a full ON phase.
        i_left_on = 0; i_right_on = 1;
        for (int k = 1; k <= 5; k++) begin
            step();
            check_eq($sformatf("sw_rled_c%0d", k), o_right_led, on_at(k));
            check_eq($sformatf("sw_lled_c%0d", k), o_left_led, 0);
            check_eq($sformatf("sw_cnt_c%0d", k), o_blink_cnt, (k + 3) / 8);
        end

        // Hazard with left also held: both lamps blink in phase.
        i_right_on = 0; i_left_on = 1; i_hazard = 1;
        for (int k = 1; k <= 16; k++) begin
            step();
            check_eq($sformatf("haz_l_c%0d", k), o_left_led, on_at(k));
            check_eq($sformatf("haz_r_c%0d", k), o_right_led, on_at(k));
        end
        check_eq("haz_cnt", o_blink_cnt, 2);
        i_hazard = 0;
        step();
        check_eq("haz_drop_l",   o_left_led, 1);
        check_eq("haz_drop_r",   o_right_led, 0);
        check_eq("haz_drop_cnt", o_blink_cnt, 0);

        // Run right for 10 cycles, then pulse finish mid ON phase with right still held.
        i_left_on = 0; i_right_on = 1;
        repeat (10) step();
        check_eq("pre_fin_r",   o_right_led, 1);
        check_eq("pre_fin_cnt", o_blink_cnt, 1);
        i_finish = 1;
        step();
        i_finish = 0;
        check_eq("fin_r",      o_right_led, 0);
        check_eq("fin_l",      o_left_led, 0);
        check_eq("fin_active", o_active, 0);
        check_eq("fin_cnt",    o_blink_cnt, 1);
        step();
        check_eq("refire_r",      o_right_led, 1);
        check_eq("refire_active", o_active, 1);
        check_eq("refire_cnt",    o_blink_cnt, 0);

        // Left joins right: hold RIGHT without restarting.
        i_left_on = 1;
        for (int k = 2; k <= 5; k++) begin
            step();
            check_eq($sformatf("hold_r_c%0d", k), o_right_led, on_at(k));
            check_eq($sformatf("hold_l_c%0d", k), o_left_led, 0);
        end
        check_eq("hold_cnt", o_blink_cnt, 1);
        i_left_on = 0; i_right_on = 0;
        step();
        check_eq("drop_active", o_active, 0);
        check_eq("drop_r",      o_right_led, 0);
        check_eq("drop_cnt",    o_blink_cnt, 1);

        // Both sides requested from IDLE: hold IDLE.
        i_left_on = 1; i_right_on = 1;
        step(); step();
        check_eq("both_idle_active", o_active, 0);
        check_eq("both_idle_l",      o_left_led, 0);
        i_left_on = 0; i_right_on = 0;

        // Saturation: 300 hazard blinks. Then reset mid ON phase with no clock edge.
        i_hazard = 1;
        repeat (300 * 8 + 2) step();
        check_eq("sat_cnt", o_blink_cnt, 255);
        check_eq("sat_l",   o_left_led, 1);
        reset = 1;
        #1;
        check_eq("async_l",      o_left_led, 0);
        check_eq("async_r",      o_right_led, 0);
        check_eq("async_active", o_active, 0);
        check_eq("async_cnt",    o_blink_cnt, 0);
        i_hazard = 0;
        step();
        reset = 0;
        step();
        check_eq("post_rst_active", o_active, 0);

        // Hold left through the third blink.
        i_left_on = 1;
        for (int k = 1; k <= 20; k++) step();
        step();
`ifdef WINKER_LANE_CHANGE_EN
        check_eq("lane_auto",   o_auto_off, 1);
        check_eq("lane_l",      o_left_led, 0);
        check_eq("lane_active", o_active, 0);
        check_eq("lane_cnt",    o_blink_cnt, 3);
        step();
        check_eq("lane_auto_once", o_auto_off, 0);
        repeat (5) step();
        check_eq("lane_locked", o_active, 0);
        check_eq("lane_locked_l", o_left_led, 0);
        i_left_on = 0;
        step();
        i_left_on = 1;
        step();
        check_eq("lane_rearm_l",   o_left_led, 1);
        check_eq("lane_rearm_cnt", o_blink_cnt, 0);
`else
        check_eq("noauto_pulse", o_auto_off, 0);
        check_eq("noauto_active", o_active, 1);
        check_eq("noauto_cnt",    o_blink_cnt, 3);
        repeat (8) step();
        check_eq("noauto_l",      o_left_led, on_at(29));
        check_eq("noauto_cnt2",   o_blink_cnt, 4);
`endif
        i_left_on = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
